// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: memory op encoding, LSU FSM states
// and small decode helpers used by the controller and the alignment logic.
package lsu_ctrl_pkg;

    // Op encoding: {prefix[1:0], unsigned, size[1:0]}
    localparam int         MEM_OP_BITS = 5;
    localparam logic [1:0] LOAD_PRFX   = 2'b01;
    localparam logic [1:0] STORE_PRFX  = 2'b10;

    typedef enum logic [MEM_OP_BITS-1:0] {
        MEM_NOP = 5'b00_0_00,
        LB      = 5'b01_0_00,
        LH      = 5'b01_0_01,
        LW      = 5'b01_0_10,
        LBU     = 5'b01_1_00,
        LHU     = 5'b01_1_01,
        SB      = 5'b10_0_00,
        SH      = 5'b10_0_01,
        SW      = 5'b10_0_10
    } mem_op_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP,
        LSU_DONE
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    function automatic logic is_load(mem_op_t op);
        logic [MEM_OP_BITS-1:0] b;
        b = op;
        return b[MEM_OP_BITS-1 -: 2] == LOAD_PRFX;
    endfunction

    function automatic logic is_store(mem_op_t op);
        logic [MEM_OP_BITS-1:0] b;
        b = op;
        return b[MEM_OP_BITS-1 -: 2] == STORE_PRFX;
    endfunction

    function automatic logic [1:0] op_size(mem_op_t op);
        logic [MEM_OP_BITS-1:0] b;
        b = op;
        return b[1:0];
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational byte-lane steering: byte enables, lane-replicated store
// data and the misalignment flag for one memory op at a given offset.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        misalign
);

    // Decode access size into lane enables and replicated data
    always_comb begin
        be       = 4'b1111;
        wdata_al = wdata;
        misalign = 1'b0;
        case (op_size(op))
            SZ_B: begin
                be       = 4'b0001 << off;
                wdata_al = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be       = off[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                misalign = off[0];
            end
            default: begin
                be       = 4'b1111;
                wdata_al = wdata;
                misalign = |off;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer. Takes one op at a time, runs a
// req/gnt/rvalid bus transaction, and stalls upstream until it finishes.
// Misaligned ops complete without touching the bus; a cycle counter turns
// a hung bus into a bus error; a flush mid-transaction drains the response
// silently.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  mem_op_t     mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  addr_offset_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    lsu_state_t       state_q, state_d;
    logic             is_ld_q;
    logic [1:0]       off_q;
    logic             kill_q;
    logic             mis_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    logic             accept;
    logic             timeout;
    logic             timeout_hit;
    logic             resp_hit;
    logic [3:0]       be_al;
    logic [31:0]      wdata_al;
    logic             mis_al;

    lsu_align u_align (
        .op       (mem_op_i),
        .off      (addr_i[1:0]),
        .wdata    (wdata_i),
        .be       (be_al),
        .wdata_al (wdata_al),
        .misalign (mis_al)
    );

    assign accept      = (state_q == LSU_IDLE) && valid_i && !flush_i &&
                         (is_load(mem_op_i) || is_store(mem_op_i));
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout     = TO_EN && (cnt_inc == TO_LIMIT);
    assign resp_hit    = (state_q == LSU_RESP) && dmem_rvalid_i;
    // A response in the same cycle as the limit still counts as a completion
    assign timeout_hit = timeout &&
                         (((state_q == LSU_REQ) && !dmem_gnt_i) ||
                          ((state_q == LSU_RESP) && !dmem_rvalid_i));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= LSU_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: a killed transaction drains to IDLE instead of DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) state_d = mis_al ? LSU_DONE : LSU_REQ;
            end
            LSU_REQ: begin
                if (flush_i && !dmem_gnt_i) state_d = LSU_IDLE;
                else if (dmem_gnt_i)        state_d = LSU_RESP;
                else if (timeout)           state_d = LSU_DONE;
            end
            LSU_RESP: begin
                if (dmem_rvalid_i || timeout)
                    state_d = (kill_q || flush_i) ? LSU_IDLE : LSU_DONE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Outputs: DONE reports the latched result unless flushed in that cycle
    always_comb begin
        stall_o       = accept || (state_q == LSU_REQ) || (state_q == LSU_RESP);
        done_o        = (state_q == LSU_DONE) && !flush_i;
        misalign_o    = done_o && mis_q;
        bus_err_o     = done_o && err_q;
        rdata_o       = rdata_q;
        addr_offset_o = off_q;
    end

    // Timeout counter and kill flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            kill_q <= 1'b0;
        end else begin
            if (accept)
                cnt_q <= '0;
            else if ((state_q == LSU_REQ) || (state_q == LSU_RESP))
                cnt_q <= cnt_inc;

            if (state_d == LSU_IDLE)
                kill_q <= 1'b0;
            else if (flush_i && (((state_q == LSU_REQ) && dmem_gnt_i) ||
                                 (state_q == LSU_RESP)))
                kill_q <= 1'b1;
        end
    end

    // Latched op, result and flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_ld_q <= 1'b0;
            off_q   <= 2'b00;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            is_ld_q <= is_load(mem_op_i);
            off_q   <= addr_i[1:0];
            mis_q   <= mis_al;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (resp_hit) begin
            rdata_q <= is_ld_q ? (dmem_rdata_i >> {off_q, 3'b000}) : '0;
        end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
        end
    end

    // Registered bus outputs, held stable from the latched op
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'b0000;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
        end else begin
            dmem_req_o <= (state_d == LSU_REQ);
            if (accept) begin
                dmem_we_o    <= is_store(mem_op_i);
                dmem_be_o    <= be_al;
                dmem_addr_o  <= {addr_i[31:2], 2'b00};
                dmem_wdata_o <= wdata_al;
            end
        end
    end

endmodule
